// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and decoder state encoding, shared by the
// timing generator and the timing decoder.
package vga_pkg;

    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_BP        = 48;
    localparam int VGA_H_ACTIVE    = 640;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_BP        = 33;
    localparam int VGA_V_ACTIVE    = 480;
    localparam int VGA_LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } vga_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Strobe-qualified edge detector for an active-low sync line; the previous
// sample idles high so a sync already low at reset release counts as a fall.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic sync,
    output logic fall,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else if (stb) begin
            prev <= sync;
        end
    end

    assign fall = stb & prev & ~sync;
    assign rise = stb & ~prev & sync;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates and data-enable from a strobed HS/VS stream and
// tracks timing lock through SEARCH -> TRACK -> LOCKED.
module vga_timing_decoder
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic       i_hs,
    input  logic       i_vs,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic       o_de,
    output logic       o_frame_start,
    output logic       o_locked,
    output logic       o_err,
    output vga_state_t o_state
);

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  HS_LAST   = 10'(H_SYNC - 1);
    localparam logic [9:0]  H_ACT_LO  = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_ACT_HI  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_LO  = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_ACT_HI  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] WD_LIMIT  = 11'(H_TOTAL);
    localparam logic [3:0]  FR_LOCK   = 4'(LOCK_FRAMES);

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    vga_state_t  state, state_n;
    logic [9:0]  hcnt, hcnt_n, vcnt, vcnt_n;
    logic [10:0] wd, wd_n;
    logic [3:0]  fcnt, fcnt_n;
    logic        vs_pend, vs_pend_n, h_synced, h_synced_n;
    logic        h_viol, v_viol, viol, active;

    sync_edge_det u_hs_edge (
        .clk   (i_clk),
        .rst_n (i_rst),
        .stb   (i_pix_stb),
        .sync  (i_hs),
        .fall  (hs_fall),
        .rise  (hs_rise)
    );

    sync_edge_det u_vs_edge (
        .clk   (i_clk),
        .rst_n (i_rst),
        .stb   (i_pix_stb),
        .sync  (i_vs),
        .fall  (vs_fall),
        .rise  (vs_rise)
    );

    // Horizontal checks need one HS fall first to give hcnt/wd a real phase.
    assign h_viol = h_synced && ((hs_fall && hcnt != H_LAST) ||
                                 (hs_rise && hcnt != HS_LAST) ||
                                 (i_pix_stb && !hs_fall && wd == WD_LIMIT));
    assign v_viol = (state != ST_SEARCH) && vs_fall && (vcnt != V_LAST);
    assign viol   = h_viol || v_viol;

    always_comb begin
        hcnt_n     = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
        vcnt_n     = vcnt;
        wd_n       = (wd == WD_LIMIT) ? wd : wd + 11'd1;
        vs_pend_n  = vs_pend | vs_fall;
        h_synced_n = viol ? 1'b0 : h_synced;
        state_n    = state;
        fcnt_n     = fcnt;
        if (hs_fall) begin
            hcnt_n     = 10'd0;
            wd_n       = 11'd0;
            vs_pend_n  = 1'b0;
            h_synced_n = 1'b1;
            if (vs_pend || vs_fall) begin
                vcnt_n = 10'd0;
            end else if (vcnt != V_LAST) begin
                vcnt_n = vcnt + 10'd1;
            end
        end
        if (viol) begin
            state_n = ST_SEARCH;
            fcnt_n  = 4'd0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    fcnt_n = 4'd0;
                    if (vs_fall) state_n = ST_TRACK;
                end
                ST_TRACK: begin
                    if (vs_fall) begin
                        if (fcnt != FR_LOCK) fcnt_n = fcnt + 4'd1;
                        if (fcnt_n == FR_LOCK) state_n = ST_LOCKED;
                    end
                end
                ST_LOCKED: state_n = ST_LOCKED;
                default:   state_n = ST_SEARCH;
            endcase
        end
        active = (hcnt_n >= H_ACT_LO) && (hcnt_n <= H_ACT_HI) &&
                 (vcnt_n >= V_ACT_LO) && (vcnt_n <= V_ACT_HI);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= ST_SEARCH;
            hcnt          <= 10'd0;
            vcnt          <= 10'd0;
            wd            <= 11'd0;
            fcnt          <= 4'd0;
            vs_pend       <= 1'b0;
            h_synced      <= 1'b0;
            o_x           <= 10'd0;
            o_y           <= 9'd0;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_err         <= 1'b0;
            o_frame_start <= 1'b0;
            if (i_pix_stb) begin
                state         <= state_n;
                hcnt          <= hcnt_n;
                vcnt          <= vcnt_n;
                wd            <= wd_n;
                fcnt          <= fcnt_n;
                vs_pend       <= vs_pend_n;
                h_synced      <= h_synced_n;
                o_err         <= viol;
                o_locked      <= (state_n == ST_LOCKED);
                o_de          <= active && (state_n == ST_LOCKED);
                o_frame_start <= active && (state_n == ST_LOCKED) &&
                                 (hcnt_n == H_ACT_LO) && (vcnt_n == V_ACT_LO);
                if (active) begin
                    o_x <= hcnt_n - H_ACT_LO;
                    o_y <= 9'(vcnt_n - V_ACT_LO);
                end
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a scaled-down raster (24x14 strobes)
// produced by an in-bench timing generator.
module tb_vga_timing_decoder;
    import vga_pkg::*;

    localparam int HT = 24, HS = 4, HB = 3, HA = 14;
    localparam int VT = 14, VS = 2, VB = 3, VA = 7;
    localparam int LF = 2;
    localparam int HST = HS + HB, VST = VS + VB;

    logic       i_clk = 1'b0;
    logic       i_rst, i_pix_stb, i_hs, i_vs;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       o_de, o_frame_start, o_locked, o_err;
    vga_state_t o_state;

    int   n_checks = 0, n_errors = 0;
    int   err_cnt = 0, pix_bad = 0, fs_cnt = 0, stb_idx = 0, last_fs = -1, fs_gap = 0;
    int   frz_bad = 0, frz_err = 0;
    logic chk_en = 1'b0, lock_at_start = 1'b0;

    vga_timing_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
        .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_frame_start(o_frame_start),
        .o_locked(o_locked), .o_err(o_err), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One generator strobe at raster position (h, v) with an HS low width of hs_w.
    task automatic pix(input int h, input int v, input int hs_w);
        bit act;
        i_pix_stb = 1'b1;
        i_hs = (h < hs_w) ? 1'b0 : 1'b1;
        i_vs = (v < VS) ? 1'b0 : 1'b1;
        @(posedge i_clk);
        #1;
        stb_idx++;
        if (o_err) err_cnt++;
        if (h == 0 && v == 0) lock_at_start = o_locked;
        if (o_frame_start) begin
            if (last_fs >= 0) fs_gap = stb_idx - last_fs;
            last_fs = stb_idx;
            fs_cnt++;
        end
        if (chk_en) begin
            act = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
            if (o_de !== act) pix_bad++;
            if (act && (int'(o_x) != h - HST || int'(o_y) != v - VST)) pix_bad++;
            if (o_frame_start !== (act && h == HST && v == VST)) pix_bad++;
        end
    endtask

    task automatic run_line(input int v, input int h0, input int h1, input int hs_w);
        for (int h = h0; h < h1; h++) pix(h, v, hs_w);
    endtask

    task automatic run_lines(input int v0, input int v1);
        for (int v = v0; v < v1; v++) run_line(v, 0, HT, HS);
    endtask

    task automatic run_frame();
        run_lines(0, VT);
    endtask

    task automatic relock();
        run_frame();
        check("relock_track", o_state, ST_TRACK);
        run_frame();
        check("relock_not_yet", o_locked, 1'b0);
        chk_en = 1'b1;
        pix_bad = 0;
        run_frame();
        check("relock_at_f3", lock_at_start, 1'b1);
        check("relock_pixels", pix_bad, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, o_x, 0);
        check({tag, "_y"}, o_y, 0);
        check({tag, "_de"}, o_de, 1'b0);
        check({tag, "_fs"}, o_frame_start, 1'b0);
        check({tag, "_locked"}, o_locked, 1'b0);
        check({tag, "_err"}, o_err, 1'b0);
        check({tag, "_state"}, o_state, ST_SEARCH);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        i_rst = 1'b0; i_pix_stb = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst = 1'b1;

        // Frames 1-2 acquire, frame 3 starts locked.
        pix(0, 0, HS);
        check("f1_track", o_state, ST_TRACK);
        check("f1_unlocked", o_locked, 1'b0);
        run_line(0, 1, HT, HS);
        run_lines(1, VT);
        run_frame();
        check("f2_unlocked", o_locked, 1'b0);
        chk_en = 1'b1;
        run_frame();
        check("f3_lock_at_start", lock_at_start, 1'b1);
        check("f3_pixels", pix_bad, 0);
        check("f1_3_no_err", err_cnt, 0);
        check("f3_fs_count", fs_cnt, 1);
        run_frame();
        check("f4_fs_count", fs_cnt, 2);
        check("fs_spacing", fs_gap, VT * HT);
        check("f4_pixels", pix_bad, 0);

        // One line shortened by a strobe.
        chk_en = 1'b0;
        run_lines(0, 5);
        run_line(5, 0, HT - 1, HS);
        pix(0, 6, HS);
        check("short_err", o_err, 1'b1);
        check("short_unlocked", o_locked, 1'b0);
        check("short_state", o_state, ST_SEARCH);
        pix(1, 6, HS);
        check("short_err_one_cycle", o_err, 1'b0);
        run_line(6, 2, HT, HS);
        run_lines(7, VT);
        check("short_err_count", err_cnt, 1);
        relock();
        check("short_relock_no_err", err_cnt, 1);

        // HS held low one strobe too long.
        chk_en = 1'b0;
        run_lines(0, 4);
        run_line(4, 0, HS + 1, HS + 1);
        pix(HS + 1, 4, HS + 1);
        check("wide_err", o_err, 1'b1);
        check("wide_state", o_state, ST_SEARCH);
        check("wide_unlocked", o_locked, 1'b0);
        run_line(4, HS + 2, HT, HS + 1);
        run_lines(5, VT);
        check("wide_err_count", err_cnt, 2);
        relock();

        // Asynchronous reset in the middle of an active line.
        chk_en = 1'b0;
        run_lines(0, VST + 1);
        run_line(VST + 1, 0, HST + 6, HS);
        check("pre_rst_de", o_de, 1'b1);
        check("pre_rst_x", o_x, 5);
        i_rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        check("post_rst_state", o_state, ST_SEARCH);
        relock();
        check("rst_relock_no_err", err_cnt, 2);

        // Strobe stall inside the active region.
        run_lines(0, VST + 2);
        run_line(VST + 2, 0, HST + 4, HS);
        check("stall_pre_x", o_x, 3);
        check("stall_pre_y", o_y, 2);
        i_pix_stb = 1'b0;
        repeat (50) begin
            @(posedge i_clk);
            #1;
            if (o_x !== 10'd3 || o_y !== 9'd2 || o_de !== 1'b1) frz_bad++;
            if (o_err) frz_err++;
        end
        check("stall_frozen", frz_bad, 0);
        check("stall_no_err", frz_err, 0);
        pix(HST + 4, VST + 2, HS);
        check("resume_x", o_x, 4);
        check("resume_y", o_y, 2);
        run_line(VST + 2, HST + 5, HT, HS);
        run_lines(VST + 3, VT);
        check("stall_frame_pixels", pix_bad, 0);
        check("stall_frame_no_err", err_cnt, 2);

        // Violation on the same strobe as a VS fall.
        chk_en = 1'b0;
        run_lines(0, VT - 1);
        run_line(VT - 1, 0, HT - 1, HS);
        pix(0, 0, HS);
        check("viol_vs_err", o_err, 1'b1);
        check("viol_vs_state", o_state, ST_SEARCH);
        check("viol_vs_unlocked", o_locked, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
